// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter: round-robin sharing of one I2C master between NUM_REQ requesters, with a watchdog timeout
module i2c_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*7-1:0] req_addr,
    input  logic [NUM_REQ-1:0]   req_rw,
    input  logic [NUM_REQ*8-1:0] req_wdata,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [7:0]           rsp_rdata,
    output logic                 rsp_err,
    output logic                 m_en,
    output logic [6:0]           m_addr,
    output logic                 m_rw,
    output logic [7:0]           m_data_in,
    input  logic                 m_busy,
    input  logic                 m_done,
    input  logic                 m_nack,
    input  logic [7:0]           m_rdata
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t        state;
    logic [IW-1:0] last, g, nxt, c;
    logic [TW-1:0] timer;
    always_comb begin
        nxt = last;
        c = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            c = IW'((int'(last) + k) % NUM_REQ);
            if (req_valid[c]) nxt = c;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last      <= IW'(NUM_REQ - 1);
            g         <= '0;
            timer     <= '0;
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            m_en      <= 1'b0;
            m_addr    <= '0;
            m_rw      <= 1'b0;
            m_data_in <= '0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            m_en      <= 1'b0;
            case (state)
                IDLE: if (|req_valid && !m_busy) begin
                    g         <= nxt;
                    m_addr    <= req_addr[int'(nxt)*7 +: 7];
                    m_rw      <= req_rw[nxt];
                    m_data_in <= req_wdata[int'(nxt)*8 +: 8];
                    req_ready <= NUM_REQ'(1) << nxt;
                    m_en      <= 1'b1;
                    state     <= ISSUE;
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    timer <= timer + TW'(1);
                    if (m_done || timer == TW'(TIMEOUT - 1)) begin
                        rsp_err   <= m_done ? m_nack : 1'b1;
                        rsp_rdata <= (m_done && m_rw && !m_nack) ? m_rdata : 8'h00;
                        rsp_valid <= NUM_REQ'(1) << g;
                        state     <= RESP;
                    end
                end
                default: begin
                    last  <= g;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_req_arbiter.sv
// tb_i2c_req_arbiter: directed stimulus with grant/response scoreboard queues checked by a monitor
module tb_i2c_req_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [27:0] req_addr;
    logic [3:0]  req_rw;
    logic [31:0] req_wdata;
    logic [3:0]  req_ready, rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err, m_en, m_rw;
    logic [6:0]  m_addr;
    logic [7:0]  m_data_in;
    logic        m_busy, m_done, m_nack;
    logic [7:0]  m_rdata;

    i2c_req_arbiter #(.NUM_REQ(4), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_rw(req_rw), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_en(m_en), .m_addr(m_addr), .m_rw(m_rw), .m_data_in(m_data_in),
        .m_busy(m_busy), .m_done(m_done), .m_nack(m_nack), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {logic [3:0] ready; logic [6:0] addr; logic rw; logic [7:0] data;} gexp_t;
    typedef struct {logic [3:0] valid; logic err; logic [7:0] rdata; int lat;} rexp_t;
    gexp_t gq[$];
    rexp_t rq[$];

    int tests = 0, fails = 0;
    int cyc = 0, gcnt = 0, rcnt = 0, gcyc = 0, rcyc = 0, last_gap = 0;
    int ng = 0, nr = 0;
    int dly_of[4];
    logic       nack_of[4];
    logic [7:0] rdata_of[4];
    int stray_cnt = 0, stray_done = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [6:0] a, input logic rw, input logic [7:0] wd,
                           input int d, input logic nk, input logic [7:0] rd);
        req_addr[7*i +: 7]  = a;
        req_rw[i]           = rw;
        req_wdata[8*i +: 8] = wd;
        dly_of[i]   = d;
        nack_of[i]  = nk;
        rdata_of[i] = rd;
    endtask

    task automatic exp_grant(input logic [3:0] r, input logic [6:0] a, input logic rw, input logic [7:0] wd);
        gq.push_back('{r, a, rw, wd});
        ng++;
    endtask

    task automatic exp_rsp(input logic [3:0] v, input logic e, input logic [7:0] rd, input int lat);
        rq.push_back('{v, e, rd, lat});
        nr++;
    endtask

    task automatic wait_cnt(input bit rsp, input int n);
        int t = 0;
        while ((rsp ? rcnt : gcnt) < n && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk(rsp ? "wait_rsp_count" : "wait_grant_count", 32'((rsp ? rcnt : gcnt) >= n), 32'd1);
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 0);
        chk({tag, "_rsp_err"},   32'(rsp_err), 0);
        chk({tag, "_m_en"},      32'(m_en), 0);
        chk({tag, "_m_addr"},    32'(m_addr), 0);
        chk({tag, "_m_rw"},      32'(m_rw), 0);
        chk({tag, "_m_data_in"}, 32'(m_data_in), 0);
    endtask

    // monitor: every grant or response the DUT presents must match the head of its queue
    initial begin
        gexp_t ge;
        rexp_t re;
        forever begin
            @(negedge clk);
            cyc++;
            if (req_ready != 4'b0 || m_en === 1'b1) begin
                if (gq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_grant: req_ready=%b m_en=%b, expected no grant", req_ready, m_en);
                end else begin
                    ge = gq.pop_front();
                    chk("grant_req_ready", 32'(req_ready), 32'(ge.ready));
                    chk("grant_m_en", 32'(m_en), 32'd1);
                    chk("grant_m_addr", 32'(m_addr), 32'(ge.addr));
                    chk("grant_m_rw", 32'(m_rw), 32'(ge.rw));
                    chk("grant_m_data_in", 32'(m_data_in), 32'(ge.data));
                end
                gcnt++;
                last_gap = cyc - rcyc;
                gcyc = cyc;
            end
            if (rsp_valid != 4'b0) begin
                if (rq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_rsp: rsp_valid=%b, expected no response", rsp_valid);
                end else begin
                    re = rq.pop_front();
                    chk("rsp_valid", 32'(rsp_valid), 32'(re.valid));
                    chk("rsp_err", 32'(rsp_err), 32'(re.err));
                    chk("rsp_rdata", 32'(rsp_rdata), 32'(re.rdata));
                    chk("rsp_latency", 32'(cyc - gcyc), 32'(re.lat));
                end
                rcnt++;
                rcyc = cyc;
            end
        end
    end

    // master model: answers each m_en after the granted requester's configured delay (0 = hang)
    initial begin
        int idx;
        m_done = 0; m_nack = 0; m_rdata = 0;
        forever begin
            @(negedge clk);
            if (stray_cnt != stray_done) begin
                m_done = 1; m_rdata = 8'hFF;
                @(negedge clk);
                m_done = 0; m_rdata = 0;
                stray_done++;
            end else if (m_en === 1'b1) begin
                idx = 0;
                for (int i = 0; i < 4; i++) if (req_ready[i]) idx = i;
                if (dly_of[idx] > 0) begin
                    repeat (dly_of[idx] - 1) @(negedge clk);
                    m_done = 1; m_nack = nack_of[idx]; m_rdata = rdata_of[idx];
                    @(negedge clk);
                    m_done = 0; m_nack = 0; m_rdata = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int g0;
        reset = 1; req_valid = 0; req_addr = 0; req_rw = 0; req_wdata = 0; m_busy = 0;
        for (int i = 0; i < 4; i++) set_req(i, 7'h00, 1'b0, 8'h00, 2, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        chk_outs_zero("reset");
        reset = 0;

        // all four requesting: strict round-robin from requester 0
        set_req(0, 7'h10, 1'b0, 8'h11, 3, 1'b0, 8'h5A);
        set_req(1, 7'h21, 1'b1, 8'h22, 3, 1'b0, 8'h5A);
        set_req(2, 7'h32, 1'b0, 8'h33, 3, 1'b0, 8'h5A);
        set_req(3, 7'h43, 1'b1, 8'h44, 3, 1'b0, 8'h5A);
        exp_grant(4'b0001, 7'h10, 1'b0, 8'h11); exp_rsp(4'b0001, 1'b0, 8'h00, 3);
        exp_grant(4'b0010, 7'h21, 1'b1, 8'h22); exp_rsp(4'b0010, 1'b0, 8'h5A, 3);
        exp_grant(4'b0100, 7'h32, 1'b0, 8'h33); exp_rsp(4'b0100, 1'b0, 8'h00, 3);
        exp_grant(4'b1000, 7'h43, 1'b1, 8'h44); exp_rsp(4'b1000, 1'b0, 8'h5A, 3);
        exp_grant(4'b0001, 7'h10, 1'b0, 8'h11); exp_rsp(4'b0001, 1'b0, 8'h00, 3);
        exp_grant(4'b0010, 7'h21, 1'b1, 8'h22); exp_rsp(4'b0010, 1'b0, 8'h5A, 3);
        req_valid = 4'b1111;
        wait_cnt(0, ng);
        req_valid = 4'b0;
        wait_cnt(1, nr);

        // single write from requester 1
        set_req(1, 7'h50, 1'b0, 8'hA5, 5, 1'b0, 8'h00);
        exp_grant(4'b0010, 7'h50, 1'b0, 8'hA5); exp_rsp(4'b0010, 1'b0, 8'h00, 5);
        req_valid = 4'b0010;
        wait_cnt(0, ng);
        req_valid = 4'b0;
        wait_cnt(1, nr);
        repeat (2) @(negedge clk);
        chk("m_addr_hold", 32'(m_addr), 32'h50);
        chk("m_data_in_hold", 32'(m_data_in), 32'hA5);

        // read from requester 2
        set_req(2, 7'h3A, 1'b1, 8'h00, 4, 1'b0, 8'h3C);
        exp_grant(4'b0100, 7'h3A, 1'b1, 8'h00); exp_rsp(4'b0100, 1'b0, 8'h3C, 4);
        req_valid = 4'b0100;
        wait_cnt(0, ng);
        req_valid = 4'b0;
        wait_cnt(1, nr);

        // NACKed write from requester 0, requester 3 queued behind it
        set_req(0, 7'h11, 1'b0, 8'h77, 3, 1'b1, 8'hEE);
        set_req(3, 7'h44, 1'b0, 8'h99, 2, 1'b0, 8'h00);
        exp_grant(4'b0001, 7'h11, 1'b0, 8'h77); exp_rsp(4'b0001, 1'b1, 8'h00, 3);
        exp_grant(4'b1000, 7'h44, 1'b0, 8'h99); exp_rsp(4'b1000, 1'b0, 8'h00, 2);
        req_valid = 4'b0001;
        wait_cnt(0, ng - 1);
        req_valid = 4'b1000;
        wait_cnt(0, ng);
        req_valid = 4'b0;
        wait_cnt(1, nr);
        chk("next_grant_gap", 32'(last_gap), 32'd2);

        // hung master: watchdog completes with error after 16 WAIT cycles
        set_req(1, 7'h2B, 1'b1, 8'h00, 0, 1'b0, 8'h00);
        exp_grant(4'b0010, 7'h2B, 1'b1, 8'h00); exp_rsp(4'b0010, 1'b1, 8'h00, 17);
        req_valid = 4'b0010;
        wait_cnt(0, ng);
        req_valid = 4'b0;
        wait_cnt(1, nr);
        repeat (2) @(negedge clk);
        stray_cnt++;
        repeat (6) @(negedge clk);
        chk("late_done_ignored", 32'(rcnt), 32'(nr));

        // m_busy holds off the grant until released
        set_req(0, 7'h05, 1'b0, 8'h06, 2, 1'b0, 8'h00);
        g0 = gcnt;
        m_busy = 1;
        req_valid = 4'b0001;
        repeat (8) @(negedge clk);
        chk("busy_blocks_grant", 32'(gcnt), 32'(g0));
        exp_grant(4'b0001, 7'h05, 1'b0, 8'h06); exp_rsp(4'b0001, 1'b0, 8'h00, 2);
        m_busy = 0;
        wait_cnt(0, ng);
        req_valid = 4'b0;
        wait_cnt(1, nr);

        // reset in WAIT abandons the transaction and restores the pointer
        set_req(2, 7'h2C, 1'b1, 8'h5D, 0, 1'b0, 8'h00);
        exp_grant(4'b0100, 7'h2C, 1'b1, 8'h5D);
        req_valid = 4'b0100;
        wait_cnt(0, ng);
        req_valid = 4'b0;
        repeat (3) @(negedge clk);
        reset = 1;
        @(negedge clk);
        chk_outs_zero("midreset");
        reset = 0;
        set_req(0, 7'h01, 1'b0, 8'h02, 2, 1'b0, 8'h00);
        set_req(3, 7'h03, 1'b1, 8'h04, 2, 1'b0, 8'h4B);
        exp_grant(4'b0001, 7'h01, 1'b0, 8'h02); exp_rsp(4'b0001, 1'b0, 8'h00, 2);
        exp_grant(4'b1000, 7'h03, 1'b1, 8'h04); exp_rsp(4'b1000, 1'b0, 8'h4B, 2);
        req_valid = 4'b1001;
        wait_cnt(0, ng - 1);
        req_valid = 4'b1000;
        wait_cnt(0, ng);
        req_valid = 4'b0;
        wait_cnt(1, nr);

        repeat (5) @(negedge clk);
        chk("grant_queue_drained", 32'(gq.size()), 32'd0);
        chk("rsp_queue_drained", 32'(rq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
